uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter that serialises one parallel word per valid/ready handshake into an asynchronous serial frame. The frame is configurable at elaboration: data width, parity mode and stop-bit count. It sits between a byte source (BRAM reader, FIFO or control FSM) and the board TX pin. It provides backpressure through `ready`, so the source can stream back-to-back frames without dropping data.

## Interface
Parameters:
- `CLK_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division); must be ≥ 2.
- `DATA_BITS`, 8: payload width; legal range 5..9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop-bit count; legal values 1 or 2.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `data` in DATA_BITS: word to send; sampled only on the accept edge.
- `valid` in 1: source has a word.
- `ready` out 1: block can accept; equals (state == IDLE).
- `tx` out 1: serial line, idle high; registered.
- `busy` out 1: high while a frame is on the line; registered.
- `done` out 1: one-cycle pulse after the final stop bit; registered.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `ready`=1, state IDLE, all counters 0. Reset asserted mid-frame aborts the frame immediately. After reset releases, no partial frame resumes.
- Accept: `valid && ready` at a rising edge. On that edge the block:
  - latches `data` into a shift register;
  - latches parity: odd gives `~^data`, even gives `^data`;
  - enters START and sets `busy`=1.
- `valid` and `data` are ignored while not IDLE.
- Frame order: start (0), data LSB first, optional parity bit, then STOP_BITS stop bits (1).
- States and transitions:
  - IDLE → START on accept.
  - START → DATA.
  - DATA → PARITY (if PARITY≠0) else STOP, after DATA_BITS bits.
  - PARITY → STOP.
  - STOP → IDLE after STOP_BITS bits.
  - Every transition fires on a bit-end tick.
- Bit timing: the baud counter runs 0..CLKS_PER_BIT-1 and clears on accept. The tick fires when the counter = CLKS_PER_BIT-1. Each bit is therefore exactly CLKS_PER_BIT cycles long.
- Bit counter width is $clog2(9); it counts data bits and stop bits and resets on each state entry.
- On the STOP→IDLE edge: `done` goes to 1 for one cycle, `busy` goes to 0, `tx` stays 1.
- Illegal parameter values stop elaboration with `$error`.

## Timing
- Frame length N = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Accept at edge 0: `tx` is 0 from edge 0 to edge CLKS_PER_BIT. The last stop bit ends at edge N.
- `done` is high between edges N and N+1. `ready` is high from edge N.
- Back-to-back: if `valid` is high at edge N, the next start bit begins at edge N+1. The minimum inter-frame gap is therefore 1 idle-high cycle; no longer gap is inserted.
- `ready` is combinational from the state register only, with no path from `valid`.

## Structure
- Package `uart_pkg` holds:
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the state enum type `tx_state_t` (IDLE, START, DATA, PARITY, STOP).
- Sub-module `uart_baud_tick`:
  - parameter CLKS_PER_BIT; inputs `clk`, `rst_n`, `clr`; output `tick`;
  - reused by the future receiver.
- Top FSM, shift register, parity latch and bit counter live in `uart_tx_cfg`.

## Test plan
Bench configuration: CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10.
- 8N1, send 0xA5.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles.
  - `done` pulses only in cycle 100→101.
  - `busy` is high for cycles 0–100.
- 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2), send 0x41.
  - `tx` = 0,1,0,0,0,0,0,1, parity 0, then 1,1.
  - Frame is 110 cycles.
- 8O1, send 0x00.
  - Parity bit = 1; frame is 110 cycles.
- Back-to-back: hold `valid`=1 with 0x55, then 0xAA on acceptance.
  - The second start bit begins exactly 1 cycle after the first frame's last stop bit ends.
  - Toggling `data` mid-frame does not change `tx`.
- Reset mid-frame: drop `rst_n` during data bit 3 of 0xFF.
  - `tx`=1, `busy`=0, `done`=0, `ready`=1 immediately, without waiting for a clock.
  - After release, a new 0x3C frame is bit-exact.
- Single-cycle `valid` pulses while `busy` are ignored.
  - No extra frame and no extra `done`.
  - Exactly one `done` pulse per accepted word.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the transmitter state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last cycle of every CLKS_PER_BIT-cycle bit.
// Latency: tick is high while the counter holds CLKS_PER_BIT-1; clr restarts the period.
// Backpressure: none; it free-runs and the user decides when a tick matters.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // Count 0..CLKS_PER_BIT-1 and wrap; clr aligns the period to a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: one word per valid/ready handshake, frame shape fixed at elaboration.
// Latency: start bit drives tx on the accept edge; frame lasts (1+DATA_BITS+par+STOP_BITS) bit times.
// Backpressure: ready is high only in IDLE; valid/data are ignored during a frame.
module uart_tx_cfg #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   import uart_pkg::*;

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BW = $clog2(9);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   tx_state_t            state;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [BW-1:0]        bit_cnt;
   logic                 tick;
   logic                 accept;

   assign ready  = (state == IDLE);
   assign accept = valid && ready;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (accept),
      .tick (tick)
   );

   // Frame sequencer: every state change, and the tx value of the next bit, lands on a bit-end tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         par_bit <= 1'b0;
         bit_cnt <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (accept) begin
                  shreg   <= data;
                  par_bit <= (PARITY == PAR_ODD) ? ~^data : ^data;
                  bit_cnt <= '0;
                  state   <= START;
                  tx      <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state   <= DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     if (PARITY != PAR_NONE) begin
                        state <= uart_pkg::PARITY;
                        tx    <= par_bit;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (tick) begin
                  state   <= STOP;
                  tx      <= 1'b1;
                  bit_cnt <= '0;
               end
            end
            STOP: begin
               if (tick) begin
                  if (bit_cnt == LAST_STOP) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     tx      <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three frame shapes (8N1, 7E2, 8O1) at 10 clocks per bit.
// Latency: each accepted word is expected on the line starting at its accept edge.
// Backpressure: stimulus waits on ready, holds valid for back-to-back, pulses valid while busy.
module tb_uart_tx_cfg;

   localparam int CPB = 10;

   typedef struct {
      logic [8:0] d;
      int         acc;
      bit         b2b;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cfg_db(input int g);
      case (g)
         1:       return 7;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_par(input int g);
      case (g)
         1:       return 2;
         2:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_sb(input int g);
      case (g)
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [8:0] cfg_first(input int g);
      case (g)
         1:       return 9'h041;
         2:       return 9'h000;
         default: return 9'h0A5;
      endcase
   endfunction

   // Expected line levels, one entry per bit time, LSB first; positions past the frame read 1.
   function automatic logic [12:0] model_bits(input logic [8:0] d, input int db, input int par);
      logic [12:0] b;
      int ones;
      b    = '1;
      b[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < db; i++) begin
         b[1+i] = d[i];
         if (d[i]) ones++;
      end
      if (par == 1) b[1+db] = ((ones % 2) == 0);
      else if (par == 2) b[1+db] = ((ones % 2) == 1);
      return b;
   endfunction

   task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL cfg%0d %s: got %0d, expected %0d", g, name, $signed(act), $signed(exp));
      end
   endtask

   task automatic flag_fail(input int g, input string name);
      tests++;
      fails++;
      $display("FAIL cfg%0d %s: bound expired or unexpected event", g, name);
   endtask

   for (genvar g = 0; g < 3; g++) begin : env
      localparam int W = cfg_db(g);
      localparam int P = cfg_par(g);
      localparam int S = cfg_sb(g);

      logic         rst_n = 1'b0;
      logic         valid = 1'b0;
      logic [W-1:0] data  = '0;
      logic         ready, tx, busy, done;
      exp_t         q[$];
      bit           fin = 1'b0;
      int           last_end = -100;

      uart_tx_cfg #(
         .CLK_FREQ (1000000),
         .BAUD     (100000),
         .DATA_BITS(W),
         .PARITY   (P),
         .STOP_BITS(S)
      ) dut (
         .clk  (clk),
         .rst_n(rst_n),
         .data (data),
         .valid(valid),
         .ready(ready),
         .tx   (tx),
         .busy (busy),
         .done (done)
      );

      task automatic idle_gap(input int n);
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data = W'($urandom);
            if (ready === 1'b0 && $urandom_range(0, 3) == 0) begin
               valid = 1'b1;
               @(negedge clk);
               valid = 1'b0;
            end
         end
      endtask

      task automatic send(input logic [8:0] d, input bit keep, input bit b2b);
         exp_t e;
         int n;
         data  = d[W-1:0];
         valid = 1'b1;
         n = 0;
         while (ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
         end
         if (ready !== 1'b1) begin
            flag_fail(g, "accept_timeout");
            valid = 1'b0;
         end else begin
            e.d = '0;
            e.d[W-1:0] = d[W-1:0];
            e.acc = cyc + 1;
            e.b2b = b2b;
            q.push_back(e);
            @(negedge clk);
            valid = keep;
            data  = W'($urandom);
         end
      endtask

      // Monitor: decode each frame off the line and compare it cycle by cycle with the model.
      initial begin : monitor
         exp_t        e;
         logic [12:0] bits;
         int          nb, first_bad, start;
         bit          aborted;
         forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) continue;
            if (tx === 1'b0) begin
               if (q.size() == 0) begin
                  flag_fail(g, "unexpected_frame");
                  for (int k = 0; k < 2000 && tx === 1'b0 && rst_n === 1'b1; k++) @(negedge clk);
               end else begin
                  e     = q.pop_front();
                  bits  = model_bits(e.d, W, P);
                  nb    = 1 + W + ((P != 0) ? 1 : 0) + S;
                  start = cyc;
                  chk(g, "start_latency", start, e.acc);
                  if (e.b2b) chk(g, "b2b_start_edge", start, last_end + 1);
                  first_bad = -1;
                  aborted   = 1'b0;
                  for (int j = 0; j < nb * CPB; j++) begin
                     if (j > 0) @(negedge clk);
                     if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                     end
                     if (first_bad < 0 && (tx !== bits[j/CPB] || busy !== 1'b1 ||
                                           done !== 1'b0 || ready !== 1'b0))
                        first_bad = j;
                  end
                  if (!aborted) begin
                     chk(g, "frame_first_bad_cycle", first_bad, -1);
                     @(negedge clk);
                     if (rst_n === 1'b1) begin
                        chk(g, "end_done", done, 1);
                        chk(g, "end_busy", busy, 0);
                        chk(g, "end_tx", tx, 1);
                        chk(g, "end_ready", ready, 1);
                        last_end = cyc;
                     end
                  end
               end
            end else begin
               if (done !== 1'b0) chk(g, "stray_done", done, 0);
               if (busy !== 1'b0) chk(g, "idle_busy", busy, 0);
               if (ready !== 1'b1) chk(g, "idle_ready", ready, 1);
            end
         end
      end

      initial begin : stim
         bit keep, prev_keep;
         int n;
         @(negedge clk);
         chk(g, "reset_tx", tx, 1);
         chk(g, "reset_busy", busy, 0);
         chk(g, "reset_done", done, 0);
         chk(g, "reset_ready", ready, 1);
         @(negedge clk);
         rst_n = 1'b1;
         idle_gap(3);

         send(cfg_first(g), 1'b0, 1'b0);
         idle_gap(130);

         send(9'h055, 1'b1, 1'b0);
         send(9'h0AA, 1'b0, 1'b1);
         idle_gap(130);

         prev_keep = 1'b0;
         for (int k = 0; k < 12; k++) begin
            keep = ($urandom_range(0, 2) == 0) && (k != 11);
            send(9'($urandom), keep, prev_keep);
            if (!keep) idle_gap($urandom_range(0, 150));
            prev_keep = keep;
         end
         idle_gap(150);

         send(9'h0FF, 1'b0, 1'b0);
         repeat (44) @(negedge clk);
         #2 rst_n = 1'b0;
         #1;
         chk(g, "midreset_tx", tx, 1);
         chk(g, "midreset_busy", busy, 0);
         chk(g, "midreset_done", done, 0);
         chk(g, "midreset_ready", ready, 1);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         idle_gap(2);
         send(9'h03C, 1'b0, 1'b0);

         n = 0;
         while ((q.size() != 0 || busy !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk(g, "queue_drained", q.size(), 0);
         idle_gap(5);
         fin = 1'b1;
      end
   end

   initial begin : main
      int t;
      t = 0;
      while (!(env[0].fin && env[1].fin && env[2].fin) && t < 60000) begin
         @(negedge clk);
         t++;
      end
      if (!(env[0].fin && env[1].fin && env[2].fin)) flag_fail(9, "global_timeout");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
